// File: rtl/muldiv_unit_pkg.sv
// Shared defines for the multiply/divide unit: word width, ALU operand
// selects, M-extension op encodings (funct3) and FSM state encoding.
`ifndef WORD
`define WORD 32
`endif

package muldiv_unit_pkg;

   localparam int WORD_W = `WORD;

   localparam logic [1:0] ALU_SRC_REG = 2'd0;
   localparam logic [1:0] ALU_SRC_IMM = 2'd1;
   localparam logic [1:0] ALU_SRC_PC  = 2'd2;

   localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // rs1 is read as signed for MULH, MULHSU, DIV, REM
   function automatic logic src1_signed(input logic [2:0] op);
      return (op == MULDIV_OP_MULH)   ||
             (op == MULDIV_OP_MULHSU) ||
             (op == MULDIV_OP_DIV)    ||
             (op == MULDIV_OP_REM);
   endfunction

   // rs2 is read as signed for MULH, DIV, REM
   function automatic logic src2_signed(input logic [2:0] op);
      return (op == MULDIV_OP_MULH) ||
             (op == MULDIV_OP_DIV)  ||
             (op == MULDIV_OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle of the multiply/divide unit.
// master: issuing stage; slave: muldiv_unit.
interface muldiv_unit_if #(
   parameter int WIDTH = `WORD
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;

   modport master (
      output in_valid, op, src1, src2, flush, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, src1, src2, flush, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes at issue, and final
// sign / divide-by-zero correction of the raw iteration result.
// Ports: op/src1/src2 -> mag1/mag2; op_q/src1_q/src2_q/hi/lo -> fixed.
module muldiv_signfix
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = `WORD
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic [WIDTH-1:0] mag1,
   output logic [WIDTH-1:0] mag2,
   input  logic [2:0]       op_q,
   input  logic [WIDTH-1:0] src1_q,
   input  logic [WIDTH-1:0] src2_q,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] fixed
);
   logic n1, n2, n1_q, n2_q, neg_p, div0;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0] quo_s, rem_s;

   assign n1   = src1_signed(op) & src1[WIDTH-1];
   assign n2   = src2_signed(op) & src2[WIDTH-1];
   assign mag1 = n1 ? -src1 : src1;
   assign mag2 = n2 ? -src2 : src2;

   assign n1_q  = src1_signed(op_q) & src1_q[WIDTH-1];
   assign n2_q  = src2_signed(op_q) & src2_q[WIDTH-1];
   assign neg_p = n1_q ^ n2_q;
   assign div0  = (src2_q == '0);

   // negating zero yields zero, so a zero result never turns negative
   always_comb begin
      prod   = {hi, lo};
      prod_s = neg_p ? -prod : prod;
      quo_s  = neg_p ? -lo : lo;
      rem_s  = n1_q ? -hi : hi;
      fixed  = '0;
      case (op_q)
         MULDIV_OP_MUL:    fixed = prod_s[WIDTH-1:0];
         MULDIV_OP_MULH,
         MULDIV_OP_MULHSU,
         MULDIV_OP_MULHU:  fixed = prod_s[2*WIDTH-1:WIDTH];
         MULDIV_OP_DIV,
         MULDIV_OP_DIVU:   fixed = div0 ? '1 : quo_s;
         MULDIV_OP_REM,
         MULDIV_OP_REMU:   fixed = div0 ? src1_q : rem_s;
         default:          fixed = '0;
      endcase
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Ports: clk, reset (sync, active-high), bus (muldiv_unit_if.slave).
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = `WORD
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  bus
);
   localparam logic [5:0] LAST = 6'(WIDTH);

   logic [1:0]       state;
   logic [5:0]       cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] src1_q, src2_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi, lo, hi_n, lo_n;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] mag1, mag2, fixed;
   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] shl, diff;

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.result    = result_q;

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .op     (bus.op),
      .src1   (bus.src1),
      .src2   (bus.src2),
      .mag1   (mag1),
      .mag2   (mag2),
      .op_q   (op_q),
      .src1_q (src1_q),
      .src2_q (src2_q),
      .hi     (hi),
      .lo     (lo),
      .fixed  (fixed)
   );

   // hi:lo is the product for multiply, remainder:quotient for divide.
   // opnd_q is the multiplicand or the divisor.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
      shl  = {1'b0, hi, lo[WIDTH-1]};
      diff = shl - {2'b0, opnd_q};
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
      if (op_q[2]) begin
         if (!diff[WIDTH+1]) begin
            hi_n = diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = shl[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         result_q <= '0;
      end else if (bus.flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state  <= ST_BUSY;
                  cnt    <= '0;
                  op_q   <= bus.op;
                  src1_q <= bus.src1;
                  src2_q <= bus.src2;
                  hi     <= '0;
                  lo     <= bus.op[2] ? mag1 : mag2;
                  opnd_q <= bus.op[2] ? mag2 : mag1;
               end
            end
            ST_BUSY: begin
               // one extra cycle after the last step for the fixup
               if (cnt == LAST) begin
                  result_q <= fixed;
                  state    <= ST_DONE;
               end else begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt + 6'd1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test of muldiv_unit: vector table plus flush/reset cases.
// Expected values are hand-computed RV32M results.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          hold;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl [20];

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic run_op(input string nm,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input int hold);
      int n;
      logic ok;
      logic [31:0] r;
      check({nm, " rdy"}, 32'(bus.in_ready), 32'd1);
      bus.op = op;
      bus.src1 = a;
      bus.src2 = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op = op ^ 3'd5;
      bus.src1 = ~a;
      bus.src2 = a ^ b ^ 32'h5a5a_1234;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, " lat"}, 32'(n), 32'd33);
      if (!bus.out_valid) begin
         bus.flush = 1'b1;
         @(posedge clk); #1;
         bus.flush = 1'b0;
         return;
      end
      check({nm, " res"}, bus.result, exp);
      ok = 1'b1;
      r = bus.result;
      repeat (hold) begin
         @(posedge clk); #1;
         if (!bus.out_valid || bus.in_ready || bus.result !== r)
            ok = 1'b0;
      end
      if (hold > 0) check({nm, " hold"}, 32'(ok), 32'd1);
      // in_valid high at the handshake edge must not be accepted
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      check({nm, " done"},
            {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
   endtask

   initial begin
      int n;
      logic seen;
      tbl[0]  = '{MULDIV_OP_MUL,    32'd7,         32'hFFFFFFFD,
                  32'hFFFFFFEB, 0};
      tbl[1]  = '{MULDIV_OP_MULH,   32'h80000000,  32'h80000000,
                  32'h40000000, 0};
      tbl[2]  = '{MULDIV_OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,
                  32'hFFFFFFFE, 0};
      tbl[3]  = '{MULDIV_OP_MULHSU, 32'hFFFFFFFF,  32'd2,
                  32'hFFFFFFFF, 0};
      tbl[4]  = '{MULDIV_OP_DIV,    32'd7,         32'd0,
                  32'hFFFFFFFF, 0};
      tbl[5]  = '{MULDIV_OP_REMU,   32'd7,         32'd0,
                  32'd7, 0};
      tbl[6]  = '{MULDIV_OP_DIV,    32'h80000000,  32'hFFFFFFFF,
                  32'h80000000, 0};
      tbl[7]  = '{MULDIV_OP_REM,    32'h80000000,  32'hFFFFFFFF,
                  32'd0, 0};
      tbl[8]  = '{MULDIV_OP_DIV,    32'hFFFFFFF9,  32'd2,
                  32'hFFFFFFFD, 0};
      tbl[9]  = '{MULDIV_OP_REM,    32'hFFFFFFF9,  32'd2,
                  32'hFFFFFFFF, 0};
      tbl[10] = '{MULDIV_OP_DIVU,   32'd100,       32'd7,
                  32'd14, 5};
      tbl[11] = '{MULDIV_OP_MUL,    32'h12345678,  32'd9,
                  32'hA3D70A38, 0};
      tbl[12] = '{MULDIV_OP_REMU,   32'd100,       32'd7,
                  32'd2, 0};
      tbl[13] = '{MULDIV_OP_DIV,    32'd7,         32'hFFFFFFFE,
                  32'hFFFFFFFD, 0};
      tbl[14] = '{MULDIV_OP_REM,    32'd7,         32'hFFFFFFFE,
                  32'd1, 0};
      tbl[15] = '{MULDIV_OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,
                  32'd0, 0};
      tbl[16] = '{MULDIV_OP_MULH,   32'hFFFFFFFF,  32'd2,
                  32'hFFFFFFFF, 0};
      tbl[17] = '{MULDIV_OP_REM,    32'hFFFFFFF8,  32'd2,
                  32'd0, 0};
      tbl[18] = '{MULDIV_OP_DIV,    32'd6,         32'hFFFFFFFD,
                  32'hFFFFFFFE, 0};
      tbl[19] = '{MULDIV_OP_MULHU,  32'h80000000,  32'd2,
                  32'd1, 0};

      bus.in_valid = 1'b0;
      bus.op = 3'd0;
      bus.src1 = '0;
      bus.src2 = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst result", bus.result, 32'd0);

      foreach (tbl[i])
         run_op($sformatf("v%0d", i), tbl[i].op, tbl[i].a,
                tbl[i].b, tbl[i].exp, tbl[i].hold);

      // flush beats acceptance in IDLE
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      bus.op = MULDIV_OP_MUL;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      check("flush vs accept", 32'(bus.in_ready), 32'd1);

      // flush 10 cycles after acceptance
      bus.op = MULDIV_OP_DIVU;
      bus.src1 = 32'd100;
      bus.src2 = 32'd7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      seen = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush in_ready", 32'(bus.in_ready), 32'd1);
      check("flush out_valid", 32'(bus.out_valid), 32'd0);
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("flush no result", 32'(seen), 32'd0);
      run_op("post flush", MULDIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 0);

      // reset in the middle of BUSY
      bus.op = MULDIV_OP_MUL;
      bus.src1 = 32'd5;
      bus.src2 = 32'd6;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
      check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
      check("mid rst result", bus.result, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("mid rst no result", 32'(seen), 32'd0);
      run_op("post rst", MULDIV_OP_MUL, 32'd5, 32'd6, 32'd30, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD (32): operand and result width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: operands and op are presented.
REQ-005 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port op, input, 3: operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), encoded as RV32M funct3.
REQ-007 SHALL have ports src1 and src2, input, WIDTH: rs1-side and rs2-side operands from the ALU operand select.
REQ-008 SHALL have port flush, input, 1: abort any in-flight operation.
REQ-009 SHALL have port out_valid, output, 1: result is valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH: product word or quotient/remainder.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, decoded combinationally from state.
REQ-014 SHALL accept a request at an edge where in_valid && in_ready && !flush; op, src1 and src2 are then latched and the FSM moves IDLE->BUSY.
REQ-015 SHALL, in BUSY, perform one radix-2 iteration per cycle: shift-add for MUL*, restoring divide for DIV*/REM*, on magnitude operands.
REQ-016 SHALL use a 6-bit iteration counter; BUSY->DONE after exactly 32 iterations.
REQ-017 SHALL apply sign correction and register result on the BUSY->DONE edge, with out_valid first high 33 cycles after the acceptance edge.
REQ-018 SHALL hold result and out_valid stable in DONE until out_valid && out_ready, then go DONE->IDLE on that edge.
REQ-019 SHALL select the result as follows: MUL gives the low WIDTH bits of the 2*WIDTH product; MULH, MULHSU and MULHU give the high WIDTH bits with signed*signed, signed*unsigned and unsigned*unsigned interpretation respectively.
REQ-020 SHALL, for divide by zero, return all-ones for DIV/DIVU and src1 for REM/REMU, and still take the full latency.
REQ-021 SHALL, for signed overflow (src1 = 0x80000000, src2 = 0xFFFFFFFF), return 0x80000000 for DIV and 0 for REM.
REQ-022 SHALL give remainder sign = dividend sign and quotient sign = XOR of operand signs, with a zero quotient or remainder never negated.
REQ-023 SHALL, when flush = 1 at an edge in any state, go to IDLE with out_valid = 0 at that edge, produce no result, and have flush take priority over acceptance and out_ready.
REQ-024 SHALL not accept a new request in the same cycle as the DONE->IDLE handshake (in_ready stays 0 in DONE).
REQ-025 SHALL ignore changes on src1, src2 and op after acceptance.

Reset
REQ-026 SHALL, on reset = 1 at a rising edge, set state = IDLE, out_valid = 0, result = 0, counter = 0 and in_ready = 1 on the following cycle.
REQ-027 SHALL let reset override flush and any handshake, and discard a mid-operation result without it appearing.

Structure
REQ-028 SHALL place the op encodings (MULDIV_OP_*) and the state encoding in the shared defines package next to the ALU_SRC_* constants, with WIDTH taken from `WORD.
REQ-029 SHALL contain one combinational sub-module, muldiv_signfix, holding operand magnitude and final sign/corner-case correction.
REQ-030 SHALL keep the FSM, counter and datapath registers in muldiv_unit.

Verification
REQ-031 SHALL cover: MUL src1 = 7, src2 = 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance.
REQ-032 SHALL cover: MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-034 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 with out_ready held low 5 cycles -> result stable and in_ready = 0 throughout.
REQ-035 SHALL cover: flush asserted 10 cycles after acceptance -> in_ready = 1 next cycle, out_valid never asserted, next request DIVU 9/3 -> 3.
REQ-036 SHALL cover: reset asserted mid-BUSY -> out_valid = 0, in_ready = 1 the cycle after, no stale result delivered.
